led_indicator: RTL and testbench
================================

Name: led_indicator

Overview:
Output-side counterpart of the switch conditioner. It converts a logical indication request into a physical LED drive waveform. Supported waveforms: steady on/off, slow/fast blink, pulse-stretched event flash, and an N-blink count display. Sits between control logic (e.g. switch counter value, status events) and the board LED pins. One instance per LED.

Parameters:
CLK_FRQ, 27_000_000, clock frequency (Hz)
STRETCH, 50, on-time for an event flash (ms)
BLINK_SLOW, 500, slow blink half-period (ms)
BLINK_FAST, 100, fast blink half-period (ms)
CNT_ON, 200, count-display on-time per blink (ms)
CNT_OFF, 200, count-display off-time between blinks (ms)
CNT_GAP, 1000, count-display gap before the sequence repeats (ms)
WIDTH, 3, width of count input
ACTIVE_LOW, 1, 1 = LED pin lit when driven 0

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous reset, active-low
mode  input  3  0 off, 1 on, 2 blink slow, 3 blink fast, 4 stretch, 5 count display, 6/7 off (reserved)
event_pulse  input  1  single-cycle trigger, used in mode 4 only
count  input  WIDTH  number of blinks for mode 5
led_log  output  1  registered logical LED state, 1 = lit
led_phy  output  1  registered pin drive = led_log XOR ACTIVE_LOW
busy  output  1  registered; 1 while a stretch flash or a count blink sequence (ON/OFF states) is in progress

Behaviour:
- Derived clocks: X_CLK = (CLK_FRQ/1000)*X for each ms parameter. One shared 28-bit timer cnt. All logic on posedge clk.
- Reset (reset_n=0 at edge): led_log=0, led_phy=ACTIVE_LOW, busy=0, cnt=0, mode_q=0, FSM=CIDLE. Reset wins over all other inputs.
- mode_q holds the registered mode. Mode change: at any edge where mode != mode_q, set mode_q<=mode and cnt<=0, and clear busy and the FSM. led_log takes the new mode's entry value at that same edge (1-clock latency from mode to pin).
- Entry values: modes 0/6/7 → 0; mode 1 → 1; modes 2/3 → 1; mode 4 → 0 unless event_pulse=1 on the same edge, which triggers the flash; mode 5 → FSM enters CLATCH, led 0.
- Modes 0/1/6/7: static; cnt is held at 0.
- Modes 2/3 (blink): HALF = BLINK_SLOW_CLK or BLINK_FAST_CLK. Every cycle cnt increments. When cnt == HALF-1: cnt<=0 and led_log toggles. Result is exactly HALF cycles lit, then HALF cycles dark, repeating.
- Mode 4 (stretch): event_pulse sets led_log=1, busy=1, cnt=0. While lit, cnt counts. When cnt == STRETCH_CLK-1: led_log=0, busy=0. An event while lit retriggers (cnt=0), extending the flash. event_pulse is ignored in all other modes.
- Mode 5 (count FSM): states CLATCH, CON, COFF, CGAP.
  - CLATCH (1 cycle): rem<=count. If count==0, go to CGAP with led 0 and busy 0. Otherwise go to CON with led 1 and busy 1.
  - CON: after CNT_ON_CLK cycles → COFF, led 0.
  - COFF: after CNT_OFF_CLK cycles, rem<=rem-1. If rem==1, go to CGAP with busy 0. Otherwise go to CON with led 1.
  - CGAP: led 0. After CNT_GAP_CLK cycles → CLATCH.
  - count is sampled only in CLATCH; changes mid-sequence take effect on the next repetition.
- Every timer state resets cnt to 0 on entry and leaves on the edge where cnt == N-1. Each state therefore lasts exactly N cycles.
- led_phy always equals led_log XOR ACTIVE_LOW on the same cycle (both registered from the same next-state).
- No wrap-around is possible: cnt never exceeds the largest *_CLK-1, which must fit in 28 bits.

Test Plan:
All scenarios use CLK_FRQ=10_000 (1 ms = 10 clk) and ACTIVE_LOW=1, with other parameters at default.
1. Reset: hold reset_n=0 with mode=1 → led_log=0, led_phy=1, busy=0. Release → led_log=1 one edge later.
2. Mode 3, run 4000 clk → led_log high exactly 1000 clk, then low 1000 clk, alternating; first high run begins at the mode-change edge.
3. Mode 4, event_pulse at t=0 and again at t=300 → led_log high continuously t=1..800, busy tracks led_log. An event in mode 2 leaves the waveform unchanged.
4. Mode 5, count=3 → three 2000-clk high pulses separated by 2000-clk lows, then 10000 clk low, then repeat. busy=0 during CGAP. count=0 → led_log constantly 0.
5. Change count 3→1 during the 2nd blink → current sequence still completes 3 blinks; the next sequence gives 1 blink.
6. Switch mode 5→1 mid-CON, then reset_n=0 mid-blink in mode 2 → led_log=1 the next edge with busy=0; reset returns all outputs to reset values on that edge.

Source files
------------

// File: rtl/led_indicator.sv
// led_indicator: turns a logical indication request into an LED pin drive.
// Waveforms: steady off/on, slow/fast blink, stretched event flash, and a
// repeating N-blink count display. One instance per LED.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous reset, active-low
//   mode         0 off, 1 on, 2 slow blink, 3 fast blink, 4 stretch,
//                5 count display, 6/7 off
//   event_pulse  single-cycle flash trigger (mode 4 only)
//   count        number of blinks shown in mode 5
//   led_log      registered logical LED state, 1 = lit
//   led_phy      registered pin drive, led_log XOR ACTIVE_LOW
//   busy         registered, high during a flash or the blink part of a count
module led_indicator #(
    parameter int unsigned CLK_FRQ    = 27_000_000,
    parameter int unsigned STRETCH    = 50,
    parameter int unsigned BLINK_SLOW = 500,
    parameter int unsigned BLINK_FAST = 100,
    parameter int unsigned CNT_ON     = 200,
    parameter int unsigned CNT_OFF    = 200,
    parameter int unsigned CNT_GAP    = 1000,
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       mode,
    input  logic             event_pulse,
    input  logic [WIDTH-1:0] count,
    output logic             led_log,
    output logic             led_phy,
    output logic             busy
);

    localparam int unsigned CNT_W  = 28;
    localparam int unsigned CLK_MS = CLK_FRQ / 1000;

    // Terminal counts: a timed phase of N cycles ends when cnt == N-1.
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(CLK_MS * STRETCH - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST    = CNT_W'(CLK_MS * BLINK_SLOW - 1);
    localparam logic [CNT_W-1:0] FAST_LAST    = CNT_W'(CLK_MS * BLINK_FAST - 1);
    localparam logic [CNT_W-1:0] ON_LAST      = CNT_W'(CLK_MS * CNT_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(CLK_MS * CNT_OFF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(CLK_MS * CNT_GAP - 1);
    localparam logic             PHY_XOR      = 1'(ACTIVE_LOW);

    typedef enum logic [2:0] {
        CIDLE  = 3'd0,
        CLATCH = 3'd1,
        CON    = 3'd2,
        COFF   = 3'd3,
        CGAP   = 3'd4
    } cstate_e;

    logic [2:0]       mode_q,  mode_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             led_q,   led_d;
    logic             phy_q;
    logic             busy_q,  busy_d;
    cstate_e          state_q, state_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [CNT_W-1:0] half_last;

    assign half_last = (mode_q == 3'd3) ? FAST_LAST : SLOW_LAST;

    // State register; led_phy is registered from the same next-state as led_log.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q  <= 3'd0;
            cnt_q   <= '0;
            led_q   <= 1'b0;
            phy_q   <= PHY_XOR;
            busy_q  <= 1'b0;
            state_q <= CIDLE;
            rem_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            phy_q   <= led_d ^ PHY_XOR;
            busy_q  <= busy_d;
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state: a mode change restarts everything at the new mode's entry value.
    always_comb begin
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        busy_d  = busy_q;
        state_d = state_q;
        rem_d   = rem_q;

        if (mode != mode_q) begin
            mode_d  = mode;
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = CIDLE;
            led_d   = 1'b0;
            case (mode)
                3'd1, 3'd2, 3'd3: led_d = 1'b1;
                3'd4: begin
                    if (event_pulse) begin
                        led_d  = 1'b1;
                        busy_d = 1'b1;
                    end
                end
                3'd5:    state_d = CLATCH;
                default: led_d = 1'b0;
            endcase
        end else begin
            case (mode_q)
                3'd2, 3'd3: begin
                    if (cnt_q == half_last) begin
                        cnt_d = '0;
                        led_d = ~led_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                3'd4: begin
                    // A new event always restarts the flash, lit or not.
                    if (event_pulse) begin
                        led_d  = 1'b1;
                        busy_d = 1'b1;
                        cnt_d  = '0;
                    end else if (led_q) begin
                        if (cnt_q == STRETCH_LAST) begin
                            led_d  = 1'b0;
                            busy_d = 1'b0;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                3'd5: begin
                    case (state_q)
                        CLATCH: begin
                            rem_d = count;
                            cnt_d = '0;
                            if (count == '0) begin
                                state_d = CGAP;
                                led_d   = 1'b0;
                                busy_d  = 1'b0;
                            end else begin
                                state_d = CON;
                                led_d   = 1'b1;
                                busy_d  = 1'b1;
                            end
                        end
                        CON: begin
                            if (cnt_q == ON_LAST) begin
                                state_d = COFF;
                                led_d   = 1'b0;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        COFF: begin
                            if (cnt_q == OFF_LAST) begin
                                cnt_d = '0;
                                rem_d = rem_q - WIDTH'(1);
                                if (rem_q == WIDTH'(1)) begin
                                    state_d = CGAP;
                                    busy_d  = 1'b0;
                                end else begin
                                    state_d = CON;
                                    led_d   = 1'b1;
                                end
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        CGAP: begin
                            led_d = 1'b0;
                            if (cnt_q == GAP_LAST) begin
                                state_d = CLATCH;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        default: begin
                            // Only reachable right after reset into mode 5 bypassed; recover.
                            state_d = CLATCH;
                            cnt_d   = '0;
                            led_d   = 1'b0;
                            busy_d  = 1'b0;
                        end
                    endcase
                end
                default: begin
                    cnt_d = '0;
                    led_d = (mode_q == 3'd1);
                end
            endcase
        end
    end

    assign led_log = led_q;
    assign led_phy = phy_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_indicator.sv
// tb_led_indicator: scoreboard bench for led_indicator at CLK_FRQ=10_000
// (1 ms = 10 clk), ACTIVE_LOW=1. The driver computes expected outputs from a
// time-since-entry / waveform-segment model and queues them; a monitor pops
// one expectation per clock and compares all three outputs.
module tb_led_indicator;

    localparam int MS     = 10;
    localparam int HALF_S = 500 * MS;
    localparam int HALF_F = 100 * MS;
    localparam int STR    = 50 * MS;
    localparam int T_ON   = 200 * MS;
    localparam int T_OFF  = 200 * MS;
    localparam int T_GAP  = 1000 * MS;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] mode;
    logic       event_pulse;
    logic [2:0] count;
    logic       led_log;
    logic       led_phy;
    logic       busy;

    led_indicator #(
        .CLK_FRQ    (10_000),
        .ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode        (mode),
        .event_pulse (event_pulse),
        .count       (count),
        .led_log     (led_log),
        .led_phy     (led_phy),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        bit led;
        bit bsy;
        bit latch;
    } seg_t;

    typedef struct {
        bit led;
        bit bsy;
    } exp_t;

    exp_t exp_q[$];
    seg_t segs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;

    // Reference model state: active mode, cycles since mode entry, last flash trigger.
    int m_mode = 0;
    int m_t    = 0;
    int m_te   = -1;
    int seg_left = 0;

    // One count-display repetition after the latch cycle.
    task automatic expand(input int n);
        for (int i = 0; i < n; i++) begin
            segs.push_back('{len: T_ON,  led: 1'b1, bsy: 1'b1, latch: 1'b0});
            segs.push_back('{len: T_OFF, led: 1'b0, bsy: 1'b1, latch: 1'b0});
        end
        segs.push_back('{len: T_GAP, led: 1'b0, bsy: 1'b0, latch: 1'b0});
        segs.push_back('{len: 1,     led: 1'b0, bsy: 1'b0, latch: 1'b1});
    endtask

    // Drive one clock of stimulus and queue the outputs expected after the next edge.
    task automatic step(input bit r, input int md, input bit ev, input int cn);
        exp_t e;
        seg_t s;
        int   half;
        reset_n     = r;
        mode        = 3'(md);
        event_pulse = ev;
        count       = 3'(cn);
        e.led = 1'b0;
        e.bsy = 1'b0;
        if (!r) begin
            m_mode = 0;
            m_t    = 0;
        end else begin
            if (md != m_mode) begin
                m_mode = md;
                m_t    = 0;
                m_te   = -1;
                if (md == 5) begin
                    segs.delete();
                    segs.push_back('{len: 1, led: 1'b0, bsy: 1'b0, latch: 1'b1});
                    seg_left = 1;
                end
            end else begin
                m_t++;
            end
            case (m_mode)
                1: e.led = 1'b1;
                2, 3: begin
                    half  = (m_mode == 2) ? HALF_S : HALF_F;
                    e.led = ((m_t / half) % 2) == 0;
                end
                4: begin
                    if (ev) m_te = m_t;
                    e.led = (m_te >= 0) && ((m_t - m_te) < STR);
                    e.bsy = e.led;
                end
                5: begin
                    if (m_t > 0) begin
                        seg_left--;
                        if (seg_left == 0) begin
                            s = segs.pop_front();
                            if (s.latch) expand(cn);
                            seg_left = segs[0].len;
                        end
                    end
                    e.led = segs[0].led;
                    e.bsy = segs[0].bsy;
                end
                default: e.led = 1'b0;
            endcase
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic act, input bit expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", nm, cyc_n, act, expv);
        end
    endtask

    // Monitor: every clock presents a new output triple; check it against the queue head.
    exp_t cur;
    always @(posedge clk) begin
        #1;
        cyc_n++;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("led_log", led_log, cur.led);
            chk("led_phy", led_phy, cur.led ^ 1'b1);
            chk("busy",    busy,    cur.bsy);
        end
    end

    initial begin
        int md;
        int hold;
        bit r;
        int cn;

        // Reset held with mode=1, then release.
        repeat (3) step(1'b0, 1, 1'b0, 0);
        repeat (5) step(1'b1, 1, 1'b0, 0);

        // Fast blink.
        repeat (4000) step(1'b1, 3, 1'b0, 0);

        // Stretch: directed retrigger, then random events.
        for (int t = 0; t < 1000; t++) step(1'b1, 4, (t == 0) || (t == 300), 0);
        for (int t = 0; t < 600; t++) step(1'b1, 4, $urandom_range(0, 99) == 0, 0);

        // Slow blink with events that must be ignored.
        for (int t = 0; t < 2500; t++) step(1'b1, 2, $urandom_range(0, 49) == 0, 0);

        // Count display: 3 blinks, count dropped to 1 during the second blink.
        for (int t = 0; t < 30000; t++) step(1'b1, 5, 1'b0, (t < 5000) ? 3 : 1);

        // Count display with count = 0.
        repeat (2) step(1'b1, 0, 1'b0, 0);
        repeat (11000) step(1'b1, 5, 1'b0, 0);

        // Leave mode 5 mid-CON, then reset in the middle of a slow blink.
        cn = int'($urandom_range(1, 7));
        repeat (1000) step(1'b1, 5, 1'b0, cn);
        repeat (10) step(1'b1, 1, 1'b0, 0);
        repeat (700) step(1'b1, 2, 1'b0, 0);
        repeat (3) step(1'b0, 2, 1'b0, 0);
        repeat (20) step(1'b1, 2, 1'b0, 0);

        // Random mode/event/count/reset mix.
        for (int i = 0; i < 300; i++) begin
            md   = int'($urandom_range(0, 7));
            hold = int'($urandom_range(1, 40));
            for (int k = 0; k < hold; k++) begin
                r = ($urandom_range(0, 19) != 0);
                step(r, md, $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
